// File: rtl/rf_multiport_pkg.sv
// Shared defaults for the multi-port integer register file: widths, depth and the x0 index.
package rf_multiport_pkg;

    localparam int RF_XLEN_DEF  = 32;
    localparam int RF_NREGS_DEF = 32;
    localparam int RF_AW_DEF    = $clog2(RF_NREGS_DEF);
    localparam int RF_X0_IDX    = 0;

endpackage : rf_multiport_pkg

// File: rtl/rf_multiport_if.sv
// Decode/writeback-side bundle of the register file: read, write, mark and conflict signals.
interface rf_multiport_if
    import rf_multiport_pkg::*;
#(
    parameter int XLEN  = RF_XLEN_DEF,
    parameter int NREGS = RF_NREGS_DEF,
    parameter int NRD   = 2,
    parameter int NWR   = 2,
    parameter int AW    = $clog2(NREGS)
);
    logic [NRD*AW-1:0]   i_rnum;
    logic [NRD*XLEN-1:0] o_rd;
    logic [NRD-1:0]      o_busy;
    logic [NWR-1:0]      i_wen;
    logic [NWR*AW-1:0]   i_wnum;
    logic [NWR*XLEN-1:0] i_wd;
    logic                i_mark_en;
    logic [AW-1:0]       i_mark_num;
    logic                o_wr_conflict;

    modport master (
        output i_rnum, i_wen, i_wnum, i_wd, i_mark_en, i_mark_num,
        input  o_rd, o_busy, o_wr_conflict
    );

    modport slave (
        input  i_rnum, i_wen, i_wnum, i_wd, i_mark_en, i_mark_num,
        output o_rd, o_busy, o_wr_conflict
    );

endinterface : rf_multiport_if

// File: rtl/rf_multiport_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, mark beats clear, x0 never busy.
module rf_scoreboard
    import rf_multiport_pkg::*;
#(
    parameter int NREGS = RF_NREGS_DEF,
    parameter int NRD   = 2,
    parameter int NWR   = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic [NRD*AW-1:0] i_rnum,
    input  logic [NWR-1:0]    i_wen,
    input  logic [NWR*AW-1:0] i_wnum,
    input  logic              i_mark_en,
    input  logic [AW-1:0]     i_mark_num,
    input  logic [NRD-1:0]    i_byp_hit,
    output logic [NRD-1:0]    o_busy
);
    logic [NREGS-1:0] busy_r;
    logic [NREGS-1:0] busy_nxt_s;

    // Next busy vector: writes clear first so a same-cycle mark leaves the bit set
    always_comb begin
        busy_nxt_s = busy_r;
        for (int p = 0; p < NWR; p++) begin
            if (i_wen[p]) begin
                busy_nxt_s[i_wnum[p*AW +: AW]] = 1'b0;
            end else begin
                busy_nxt_s = busy_nxt_s;
            end
        end
        if (i_mark_en) begin
            busy_nxt_s[i_mark_num] = 1'b1;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
        busy_nxt_s[0] = 1'b0;
    end

    // Busy bit storage
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            busy_r <= '0;
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    // Per-read-port busy lookup, suppressed when the read is being forwarded
    always_comb begin
        o_busy = '0;
        for (int k = 0; k < NRD; k++) begin
            o_busy[k] = busy_r[i_rnum[k*AW +: AW]] & ~i_byp_hit[k];
        end
    end

endmodule : rf_scoreboard

// File: rtl/rf_multiport.sv
// Parametrised multi-port register file with x0 = 0, pending-write scoreboard and write-collision flag.
// Define RF_BYPASS_EN to forward same-cycle write data to matching read ports.
module rf_multiport
    import rf_multiport_pkg::*;
#(
    parameter int XLEN  = RF_XLEN_DEF,
    parameter int NREGS = RF_NREGS_DEF,
    parameter int NRD   = 2,
    parameter int NWR   = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    rf_multiport_if.slave bus
);
    localparam logic [AW-1:0] X0_IDX = AW'(RF_X0_IDX);

    logic [XLEN-1:0]     regs_r [NREGS];
    logic                wr_conflict_r;
    logic                wr_conflict_s;
    logic [NWR-1:0]      wr_act_s;
    logic [NRD-1:0]      byp_hit_s;
    logic [NRD*XLEN-1:0] rd_s;
    logic [AW-1:0]       rnum_s;

    // A write port is live only when enabled and aimed at a real register
    always_comb begin
        wr_act_s = '0;
        for (int p = 0; p < NWR; p++) begin
            wr_act_s[p] = bus.i_wen[p] && (bus.i_wnum[p*AW +: AW] != X0_IDX);
        end
    end

    // Collision detect across every pair of live write ports
    always_comb begin
        wr_conflict_s = 1'b0;
        for (int i = 0; i < NWR; i++) begin
            for (int j = i + 1; j < NWR; j++) begin
                wr_conflict_s = wr_conflict_s | (wr_act_s[i] && wr_act_s[j] &&
                                (bus.i_wnum[i*AW +: AW] == bus.i_wnum[j*AW +: AW]));
            end
        end
    end

    // Storage: ascending port order so the highest-numbered port wins a collision
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_r[r] <= '0;
            end
        end else begin
            for (int p = 0; p < NWR; p++) begin
                if (wr_act_s[p]) begin
                    regs_r[bus.i_wnum[p*AW +: AW]] <= bus.i_wd[p*XLEN +: XLEN];
                end
            end
        end
    end

    // Conflict flag register
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wr_conflict_r <= 1'b0;
        end else begin
            wr_conflict_r <= wr_conflict_s;
        end
    end

    // Combinational read ports with optional same-cycle forwarding
    always_comb begin
        rd_s      = '0;
        byp_hit_s = '0;
        rnum_s    = '0;
        for (int k = 0; k < NRD; k++) begin
            rnum_s = bus.i_rnum[k*AW +: AW];
            if (rnum_s != X0_IDX) begin
                rd_s[k*XLEN +: XLEN] = regs_r[rnum_s];
            end else begin
                rd_s[k*XLEN +: XLEN] = '0;
            end
`ifdef RF_BYPASS_EN
            for (int p = 0; p < NWR; p++) begin
                if (wr_act_s[p] && (bus.i_wnum[p*AW +: AW] == rnum_s)) begin
                    rd_s[k*XLEN +: XLEN] = bus.i_wd[p*XLEN +: XLEN];
                    byp_hit_s[k]         = 1'b1;
                end else begin
                    byp_hit_s[k] = byp_hit_s[k];
                end
            end
`else
            byp_hit_s[k] = 1'b0;
`endif
        end
    end

    assign bus.o_rd          = rd_s;
    assign bus.o_wr_conflict = wr_conflict_r;

    rf_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .NWR   (NWR),
        .AW    (AW)
    ) u_scoreboard (
        .i_clk      (i_clk),
        .i_rstn     (i_rstn),
        .i_rnum     (bus.i_rnum),
        .i_wen      (bus.i_wen),
        .i_wnum     (bus.i_wnum),
        .i_mark_en  (bus.i_mark_en),
        .i_mark_num (bus.i_mark_num),
        .i_byp_hit  (byp_hit_s),
        .o_busy     (bus.o_busy)
    );

endmodule : rf_multiport

// File: tb/tb_rf_multiport.sv
// Self-checking bench: directed cases on the default build plus a random run on a 64x16, 3R/1W build.
`timescale 1ns/1ps
module tb_rf_multiport;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    rf_multiport_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) ia ();
    rf_multiport_if #(.XLEN(64), .NREGS(16), .NRD(3), .NWR(1)) ib ();

    rf_multiport #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) u_a (
        .i_clk (clk), .i_rstn (rstn), .bus (ia)
    );
    rf_multiport #(.XLEN(64), .NREGS(16), .NRD(3), .NWR(1)) u_b (
        .i_clk (clk), .i_rstn (rstn), .bus (ib)
    );

    typedef struct {
        int unsigned dut;
        int unsigned kind;
        int unsigned port;
        logic [63:0] exp;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned checks_cnt = 0;
    int unsigned errors_cnt = 0;
    logic [63:0] mem_b  [16];
    logic        busy_b [16];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] observe(input exp_t e);
        logic [63:0] v;
        v = 64'h0;
        if (e.dut == 0) begin
            case (e.kind)
                0:       v = 64'(ia.o_rd[e.port*32 +: 32]);
                1:       v = 64'(ia.o_busy[e.port]);
                default: v = 64'(ia.o_wr_conflict);
            endcase
        end else begin
            case (e.kind)
                0:       v = ib.o_rd[e.port*64 +: 64];
                1:       v = 64'(ib.o_busy[e.port]);
                default: v = 64'(ib.o_wr_conflict);
            endcase
        end
        return v;
    endfunction

    task automatic push(input int unsigned dut, input int unsigned kind,
                        input int unsigned port, input logic [63:0] e);
        exp_t x;
        x.dut = dut; x.kind = kind; x.port = port; x.exp = e;
        sb_q.push_back(x);
    endtask

    task automatic drain();
        exp_t  e;
        string nm;
        while (sb_q.size() > 0) begin
            e  = sb_q.pop_front();
            nm = (e.kind == 0) ? "rd" : (e.kind == 1) ? "busy" : "conflict";
            chk($sformatf("%s_%s%0d", (e.dut == 0) ? "a" : "b", nm, e.port), observe(e), e.exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_now();
        #2;
        drain();
    endtask

    task automatic a_idle();
        ia.i_rnum = '0; ia.i_wen = '0; ia.i_wnum = '0; ia.i_wd = '0;
        ia.i_mark_en = 1'b0; ia.i_mark_num = '0;
    endtask

    task automatic b_idle();
        ib.i_rnum = '0; ib.i_wen = '0; ib.i_wnum = '0; ib.i_wd = '0;
        ib.i_mark_en = 1'b0; ib.i_mark_num = '0;
    endtask

    task automatic a_wr(input int p, input logic [4:0] idx, input logic [31:0] d);
        ia.i_wen[p]          = 1'b1;
        ia.i_wnum[p*5 +: 5]  = idx;
        ia.i_wd[p*32 +: 32]  = d;
    endtask

    task automatic a_rd(input int k, input logic [4:0] idx);
        ia.i_rnum[k*5 +: 5] = idx;
    endtask

    task automatic a_mark(input logic [4:0] idx);
        ia.i_mark_en  = 1'b1;
        ia.i_mark_num = idx;
    endtask

    initial begin
        logic        we, me;
        logic [3:0]  wn, mn;
        logic [63:0] wd, e;
        logic        bz;
        logic [3:0]  rn [3];

        for (int r = 0; r < 16; r++) begin
            mem_b[r]  = 64'h0;
            busy_b[r] = 1'b0;
        end
        rstn = 1'b0;
        a_idle();
        b_idle();
        repeat (2) step();
        a_rd(0, 5'd5); a_rd(1, 5'd3);
        push(0, 0, 0, 64'h0); push(0, 0, 1, 64'h0);
        push(0, 1, 0, 64'h0); push(0, 1, 1, 64'h0); push(0, 2, 0, 64'h0);
        check_now();
        rstn = 1'b1;
        step();

        // Populate x5 and mark it busy, then reset in the middle of a colliding write
        a_idle(); a_wr(0, 5'd5, 32'h0000_CAFE); a_mark(5'd5);
        step();
        a_idle(); a_rd(0, 5'd5);
        push(0, 0, 0, 64'h0000_CAFE); push(0, 1, 0, 64'h1);
        check_now();
        step();
        a_wr(0, 5'd5, 32'h0000_1111); a_wr(1, 5'd5, 32'h0000_2222); a_rd(0, 5'd5);
        #2;
        rstn = 1'b0;
        push(0, 0, 0, 64'h0); push(0, 1, 0, 64'h0); push(0, 2, 0, 64'h0);
        check_now();
        step();
        a_idle(); a_rd(0, 5'd5);
        push(0, 0, 0, 64'h0); push(0, 1, 0, 64'h0); push(0, 2, 0, 64'h0);
        check_now();
        rstn = 1'b1;
        step();
        push(0, 0, 0, 64'h0); push(0, 2, 0, 64'h0);
        check_now();

        // Basic write, then x0 write discarded
        a_idle(); a_wr(0, 5'd3, 32'hDEAD_BEEF);
        step();
        a_idle(); a_rd(0, 5'd3); a_rd(1, 5'd3);
        push(0, 0, 0, 64'hDEAD_BEEF); push(0, 0, 1, 64'hDEAD_BEEF);
        check_now();
        a_wr(0, 5'd0, 32'h0000_1234);
        step();
        a_idle(); a_rd(0, 5'd0); a_rd(1, 5'd0);
        push(0, 0, 0, 64'h0); push(0, 0, 1, 64'h0); push(0, 2, 0, 64'h0);
        check_now();

        // Collision on x7, then two independent writes with no collision
        a_wr(0, 5'd7, 32'h11); a_wr(1, 5'd7, 32'h22);
        step();
        a_idle(); a_rd(0, 5'd7);
        push(0, 0, 0, 64'h22); push(0, 2, 0, 64'h1);
        check_now();
        a_wr(0, 5'd10, 32'hAA); a_wr(1, 5'd11, 32'hBB);
        step();
        a_idle(); a_rd(0, 5'd10); a_rd(1, 5'd11);
        push(0, 0, 0, 64'hAA); push(0, 0, 1, 64'hBB); push(0, 2, 0, 64'h0);
        check_now();
        step();
        push(0, 2, 0, 64'h0);
        check_now();

        // Scoreboard mark / clear / simultaneous mark+write on x9
        a_idle(); a_mark(5'd9);
        step();
        a_idle(); a_rd(0, 5'd9); a_rd(1, 5'd3);
        push(0, 1, 0, 64'h1); push(0, 1, 1, 64'h0);
        check_now();
        a_wr(1, 5'd9, 32'h99);
        step();
        a_idle(); a_rd(0, 5'd9);
        push(0, 1, 0, 64'h0); push(0, 0, 0, 64'h99);
        check_now();
        a_mark(5'd9); a_wr(0, 5'd9, 32'h77);
        step();
        a_idle(); a_rd(0, 5'd9);
        push(0, 1, 0, 64'h1); push(0, 0, 0, 64'h77);
        check_now();

        // Same-cycle write and read of x4 while x4 is marked busy
        a_idle(); a_wr(0, 5'd4, 32'h4); a_mark(5'd4);
        step();
        a_idle(); a_wr(1, 5'd4, 32'hA5A5); a_rd(1, 5'd4);
`ifdef RF_BYPASS_EN
        push(0, 0, 1, 64'hA5A5); push(0, 1, 1, 64'h0);
`else
        push(0, 0, 1, 64'h4); push(0, 1, 1, 64'h1);
`endif
        check_now();
        step();
        a_idle(); a_rd(1, 5'd4);
        push(0, 0, 1, 64'hA5A5); push(0, 1, 1, 64'h0);
        check_now();

        // Random traffic on the 64-bit, 16-entry, 3R/1W build against a reference model
        a_idle();
        step();
        for (int n = 0; n < 300; n++) begin
            we = ($urandom_range(0, 3) != 0);
            wn = 4'($urandom_range(0, 15));
            wd = {$urandom, $urandom};
            me = ($urandom_range(0, 3) == 0);
            mn = 4'($urandom_range(0, 15));
            for (int k = 0; k < 3; k++) begin
                rn[k] = ($urandom_range(0, 4) == 0) ? wn : 4'($urandom_range(0, 15));
            end
            ib.i_wen = we; ib.i_wnum = wn; ib.i_wd = wd;
            ib.i_mark_en = me; ib.i_mark_num = mn;
            for (int k = 0; k < 3; k++) begin
                ib.i_rnum[k*4 +: 4] = rn[k];
                e  = (rn[k] == 4'd0) ? 64'h0 : mem_b[rn[k]];
                bz = busy_b[rn[k]];
`ifdef RF_BYPASS_EN
                if (we && (wn != 4'd0) && (wn == rn[k])) begin
                    e  = wd;
                    bz = 1'b0;
                end
`endif
                push(1, 0, k, e);
                push(1, 1, k, 64'(bz));
            end
            push(1, 2, 0, 64'h0);
            check_now();
            if (we && (wn != 4'd0)) begin
                mem_b[wn]  = wd;
                busy_b[wn] = 1'b0;
            end
            if (me && (mn != 4'd0)) begin
                busy_b[mn] = 1'b1;
            end
            step();
        end
        b_idle();
        step();

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule : tb_rf_multiport
